// File: rtl/gayle_irq_ctrl.sv
// Gayle register block: CS/CHG/ENA/CFG/ID registers with edge-latched IDE channel IRQs.
// Reads are combinational, irq is registered one edge after chg; no backpressure, CPU strobes always accepted.
module gayle_irq_ctrl #(
  parameter int                 NCH      = 2,
  parameter int                 ID_BITS  = 4,
  parameter logic [ID_BITS-1:0] ID_VALUE = 4'hD,
  parameter bit                 SYNC_IRQ = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     addr,
  input  logic           sel_ide,
  input  logic           sel_gayle,
  input  logic           rd,
  input  logic           wr,
  input  logic [7:0]     data_in,
  output logic [15:0]    data_out,
  input  logic [NCH-1:0] ch_irq,
  output logic           irq,
  output logic [3:0]     cfg
);

  localparam int CNT_W = $clog2(ID_BITS);
  localparam logic [CNT_W-1:0] ID_LAST = CNT_W'(ID_BITS - 1);

  logic           sel_cs, sel_chg, sel_ena, sel_cfg, sel_id;
  logic           wr_d, wr_stb;
  logic           rd_id, rd_id_d, id_fall;
  logic [NCH-1:0] s2, s3, rise;
  logic [NCH-1:0] chg, chg_nxt, ena_ch;
  logic           ena_g;
  logic [5:0]     cs_mask;
  logic [1:0]     cs;
  logic [CNT_W-1:0] id_cnt;
  logic [(2**CNT_W)-1:0] id_rev;
  logic [3:0]     chg4, ena4;

  assign sel_cs  = sel_ide & (addr == 4'h8);
  assign sel_chg = sel_ide & (addr == 4'h9);
  assign sel_ena = sel_ide & (addr == 4'hA);
  assign sel_cfg = sel_ide & (addr == 4'hB);
  assign sel_id  = sel_gayle & (addr == 4'h1);

  assign wr_stb  = wr & ~wr_d;
  assign rd_id   = rd & sel_id;
  assign id_fall = rd_id_d & ~rd_id;

  generate
    if (SYNC_IRQ) begin : g_sync
      logic [NCH-1:0] s1;
      logic [NCH-1:0] s2_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1   <= '0;
          s2_q <= '0;
        end else begin
          s1   <= ch_irq;
          s2_q <= s1;
        end
      end
      assign s2 = s2_q;
    end else begin : g_nosync
      assign s2 = ch_irq;
    end
  endgenerate

  assign rise = s2 & ~s3;

  // A rise in the same cycle as a clearing write must survive, so set is applied last.
  always_comb begin
    chg_nxt = chg;
    if (wr_stb && sel_chg) begin
      for (int i = 0; i < NCH; i++) begin
        if (!data_in[7] || !data_in[i]) chg_nxt[i] = 1'b0;
      end
    end
    chg_nxt = chg_nxt | rise;
  end

  // ID sequence is stored reversed so id_cnt indexes it directly, MSB first.
  always_comb begin
    id_rev = '0;
    for (int k = 0; k < ID_BITS; k++) id_rev[k] = ID_VALUE[ID_BITS-1-k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_d    <= 1'b0;
      rd_id_d <= 1'b0;
      s3      <= '0;
      chg     <= '0;
      ena_ch  <= '0;
      ena_g   <= 1'b0;
      cs_mask <= '0;
      cs      <= '0;
      cfg     <= '0;
      id_cnt  <= '0;
      irq     <= 1'b0;
    end else begin
      wr_d    <= wr;
      rd_id_d <= rd_id;
      s3      <= s2;
      chg     <= chg_nxt;
      irq     <= ena_g & |(chg & ena_ch);
      if (wr_stb && sel_cs) begin
        cs_mask <= data_in[7:2];
        cs      <= data_in[1:0];
      end
      if (wr_stb && sel_ena) begin
        ena_g  <= data_in[7];
        ena_ch <= data_in[NCH-1:0];
      end
      if (wr_stb && sel_cfg) cfg <= data_in[7:4];
      if (wr_stb && sel_id) begin
        id_cnt <= '0;
      end else if (id_fall) begin
        id_cnt <= (id_cnt == ID_LAST) ? '0 : id_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    chg4 = '0;
    ena4 = '0;
    chg4[NCH-1:0] = chg;
    ena4[NCH-1:0] = ena_ch;
  end

  always_comb begin
    data_out = 16'h0000;
    if (rd) begin
      if (sel_cs)  data_out = data_out | {cs_mask[5] | (|s2), cs_mask[4:0], cs, 8'h00};
      if (sel_chg) data_out = data_out | {|chg, 3'b000, chg4, 8'h00};
      if (sel_ena) data_out = data_out | {ena_g, 3'b000, ena4, 8'h00};
      if (sel_cfg) data_out = data_out | {cfg, 12'h000};
      if (sel_id)  data_out = data_out | {id_rev[id_cnt], 15'b0};
    end
  end

endmodule

// File: tb/tb_gayle_irq_ctrl.sv
// Scoreboard bench for gayle_irq_ctrl: read expectations queued at issue, compared when data_out is sampled.
module tb_gayle_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  addr = 4'h0;
  logic        sel_ide = 1'b0;
  logic        sel_gayle = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [15:0] data_out;
  logic [1:0]  ch_irq = 2'b00;
  logic        irq;
  logic [3:0]  cfg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  gayle_irq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .sel_ide   (sel_ide),
    .sel_gayle (sel_gayle),
    .rd        (rd),
    .wr        (wr),
    .data_in   (data_in),
    .data_out  (data_out),
    .ch_irq    (ch_irq),
    .irq       (irq),
    .cfg       (cfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic is_ide, input logic [3:0] a, input logic [7:0] d,
                           input bit gap = 1'b1);
    @(negedge clk);
    sel_ide = is_ide; sel_gayle = !is_ide; addr = a; data_in = d; wr = 1'b1;
    tick();
    wr = 1'b0; sel_ide = 1'b0; sel_gayle = 1'b0;
    if (gap) tick();
  endtask

  task automatic cpu_read(input logic is_ide, input logic [3:0] a, input logic [15:0] exp,
                          input string tag);
    @(negedge clk);
    sel_ide = is_ide; sel_gayle = !is_ide; addr = a; rd = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    chk(tag_q.pop_front(), data_out, exp_q.pop_front());
    rd = 1'b0; sel_ide = 1'b0; sel_gayle = 1'b0;
    tick();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_async_irq", {15'b0, irq}, 16'h0000);
    chk("rst_async_cfg", {12'b0, cfg}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("reset_irq", {15'b0, irq}, 16'h0000);
    chk("idle_data_out", data_out, 16'h0000);
    cpu_read(1, 4'h8, 16'h0000, "reset_cs");
    cpu_read(1, 4'h9, 16'h0000, "reset_chg");
    cpu_read(1, 4'hA, 16'h0000, "reset_ena");
    cpu_read(1, 4'hB, 16'h0000, "reset_cfg");

    // ID sequence 1,1,0,1 then restart after a write
    cpu_read(0, 4'h1, 16'h8000, "id_bit0");
    cpu_read(0, 4'h1, 16'h8000, "id_bit1");
    cpu_read(0, 4'h1, 16'h0000, "id_bit2");
    cpu_read(0, 4'h1, 16'h8000, "id_bit3");
    cpu_write(0, 4'h1, 8'h00);
    cpu_read(0, 4'h1, 16'h8000, "id_rst_bit0");
    cpu_read(0, 4'h1, 16'h8000, "id_rst_bit1");

    // Single-channel interrupt path and latency
    cpu_write(1, 4'hA, 8'h81);
    @(negedge clk);
    ch_irq = 2'b01;
    tick();
    @(negedge clk);
    ch_irq = 2'b00;
    tick();
    chk("irq_edge2", {15'b0, irq}, 16'h0000);
    tick();
    chk("irq_edge3", {15'b0, irq}, 16'h0000);
    tick();
    chk("irq_edge4", {15'b0, irq}, 16'h0001);
    cpu_read(1, 4'h9, 16'h8100, "chg_ch0");
    cpu_write(1, 4'h9, 8'h00, 1'b0);
    chk("irq_at_clear", {15'b0, irq}, 16'h0001);
    tick();
    chk("irq_after_clear", {15'b0, irq}, 16'h0000);
    cpu_read(1, 4'h9, 16'h0000, "chg_cleared");

    // Per-channel enable masking
    cpu_write(1, 4'hA, 8'h82);
    cpu_read(1, 4'hA, 16'h8200, "ena_82");
    @(negedge clk);
    ch_irq = 2'b01;
    tick(5);
    chk("irq_masked", {15'b0, irq}, 16'h0000);
    cpu_read(1, 4'h9, 16'h8100, "chg_masked");
    @(negedge clk);
    ch_irq = 2'b11;
    tick(5);
    chk("irq_ch1", {15'b0, irq}, 16'h0001);
    cpu_read(1, 4'h9, 16'h8300, "chg_both");
    @(negedge clk);
    ch_irq = 2'b00;
    cpu_write(1, 4'h9, 8'h00);
    tick(3);
    cpu_read(1, 4'h9, 16'h0000, "chg_clear_all");

    // Rise on ch1 coinciding with a clearing write of 8'h80
    @(negedge clk);
    ch_irq = 2'b01;
    tick(4);
    @(negedge clk);
    ch_irq = 2'b11;
    tick(2);
    cpu_write(1, 4'h9, 8'h80);
    cpu_read(1, 4'h9, 16'h8200, "chg_set_wins");

    // CS, CFG, unmapped, then reset mid ID sequence
    @(negedge clk);
    ch_irq = 2'b00;
    cpu_write(1, 4'h9, 8'h00);
    tick(3);
    cpu_write(1, 4'h8, 8'hC2);
    cpu_read(1, 4'h8, 16'hC200, "cs_c2");
    cpu_write(1, 4'hB, 8'hA5);
    cpu_read(1, 4'hB, 16'hA000, "cfg_read");
    chk("cfg_port", {12'b0, cfg}, 16'h000A);
    cpu_write(1, 4'hC, 8'hFF);
    cpu_read(1, 4'hC, 16'h0000, "unmapped_da");
    cpu_read(0, 4'h2, 16'h0000, "unmapped_de");
    cpu_write(0, 4'h1, 8'h00);
    cpu_read(0, 4'h1, 16'h8000, "pre_rst_id0");
    cpu_read(0, 4'h1, 16'h8000, "pre_rst_id1");
    pulse_reset();
    tick();
    cpu_read(0, 4'h1, 16'h8000, "post_rst_id0");
    cpu_read(0, 4'h1, 16'h8000, "post_rst_id1");
    cpu_read(0, 4'h1, 16'h0000, "post_rst_id2");
    cpu_read(1, 4'h8, 16'h0000, "post_rst_cs");
    cpu_read(1, 4'h9, 16'h0000, "post_rst_chg");
    cpu_read(1, 4'hA, 16'h0000, "post_rst_ena");
    cpu_read(1, 4'hB, 16'h0000, "post_rst_cfg");
    chk("post_rst_irq", {15'b0, irq}, 16'h0000);

    // ch_irq held through reset yields exactly one rise
    @(negedge clk);
    ch_irq = 2'b01;
    tick(4);
    pulse_reset();
    tick(4);
    cpu_read(1, 4'h9, 16'h8100, "held_rise");
    cpu_write(1, 4'h9, 8'h00);
    tick(4);
    cpu_read(1, 4'h9, 16'h0000, "held_no_rerise");
    cpu_read(1, 4'h8, 16'h8000, "cs_irq_level");

    chk("sb_empty", 16'(exp_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
